// File: rtl/melody_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// melody_sequencer_pkg
//   Shared definitions for the melody sequencer. The ROM word layout, the end
//   marker and the state encoding are also used by the song ROM generator and
//   the testbench.
//
//   ROM word: [15:11] duration in ticks (0 = end of song)
//             [10:0]  frequency in Hz    (0 = rest)
// -----------------------------------------------------------------------------
package melody_sequencer_pkg;

    localparam int DUR_MSB  = 15;
    localparam int DUR_LSB  = 11;
    localparam int FREQ_MSB = 10;

    localparam logic [4:0] END_MARK = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // A note only gets an articulation gap when it is longer than the gap;
    // shorter notes play for their full duration.
    function automatic logic has_gap(input logic [4:0] dur, input logic [4:0] gap);
        return (gap != 5'd0) && (dur > gap);
    endfunction

    // Number of sounding ticks of a note (the remainder of dur is gap).
    function automatic logic [4:0] play_ticks(input logic [4:0] dur, input logic [4:0] gap);
        return has_gap(dur, gap) ? (dur - gap) : dur;
    endfunction

endpackage

// File: rtl/melody_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// melody_sequencer_tick_gen
//   Free-running divider that produces the duration tick. While en is high it
//   counts 0..TICK_DIV-1 and raises tick during the last count, so the first
//   tick arrives exactly TICK_DIV cycles after the counter leaves clear.
//
//   sclk  in  system clock
//   nrst  in  asynchronous active-low reset
//   clr   in  synchronous clear of the divider (wins over en)
//   en    in  count enable
//   tick  out one-cycle pulse every TICK_DIV enabled cycles
// -----------------------------------------------------------------------------
module melody_sequencer_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic sclk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff block sees the pre-edge value of every other register.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//   Walks a song ROM entry by entry. Each entry is fetched (ROM_LAT+1 cycles,
//   tone held), then sounds for play_ticks ticks, then stays silent for the
//   articulation gap. A zero duration marks the end of the song, after which
//   the sequencer either loops to address 0 or pulses done and idles.
//
//   sclk       in   system clock
//   nrst       in   asynchronous active-low reset
//   start      in   pulse: begin playback at address 0 (ignored unless idle)
//   stop       in   pulse: abort playback (wins over start)
//   loop_en    in   restart at address 0 at the end marker instead of finishing
//   rom_addr   out  song ROM address (registered)
//   rom_data   in   ROM word, valid ROM_LAT cycles after rom_addr changes
//   tone_freq  out  frequency for the period converter, 0 = silence
//   playing    out  high in every state except IDLE
//   done       out  one-cycle pulse when a non-looping song ends
//
//   Parameter constraints: TICK_DIV >= 2, ROM_LAT >= 1, GAP_TICKS < 32,
//   SONG_LEN <= 65536.
// -----------------------------------------------------------------------------
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int TICK_HZ   = 16,
    parameter int SONG_LEN  = 700,
    parameter int GAP_TICKS = 1,
    parameter int ROM_LAT   = 2
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [10:0] tone_freq,
    output logic        playing,
    output logic        done
);

    localparam int             TICK_DIV  = CLK_FREQ / TICK_HZ;
    localparam int             LAT_W     = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ROM_LAT - 1);
    localparam logic [4:0]     GAP5      = 5'(GAP_TICKS);
    localparam logic [15:0]    LAST_ADDR = 16'(SONG_LEN - 1);

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [4:0]       rem_cnt;
    logic [4:0]       dur_q;
    logic             tick;
    logic             tick_en;
    logic [4:0]       rom_dur;
    logic [15:0]      addr_next;

    assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
    assign addr_next = (rom_addr == LAST_ADDR) ? 16'd0 : rom_addr + 16'd1;
    assign tick_en   = (state == ST_PLAY) || (state == ST_GAP);

    // Held clear outside PLAY/GAP, so every note starts its first tick period
    // from zero on PLAY entry.
    melody_sequencer_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sclk (sclk),
        .nrst (nrst),
        .clr  (!tick_en),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            rom_addr  <= '0;
            tone_freq <= '0;
            playing   <= 1'b0;
            done      <= 1'b0;
            lat_cnt   <= '0;
            rem_cnt   <= '0;
            dur_q     <= '0;
        end else if (stop) begin
            // Harmless in IDLE, so a simultaneous start is simply dropped.
            state     <= ST_IDLE;
            tone_freq <= '0;
            playing   <= 1'b0;
            done      <= 1'b0;
            lat_cnt   <= '0;
            rem_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        playing  <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else begin
                        dur_q <= rom_dur;
                        if (rom_dur == END_MARK) begin
                            // loop_en is taken here so the done pulse shown in
                            // FINISH and the exit path out of FINISH agree.
                            if (!loop_en) begin
                                tone_freq <= '0;
                                done      <= 1'b1;
                            end
                            state <= ST_FINISH;
                        end else begin
                            tone_freq <= rom_data[FREQ_MSB:0];
                            rem_cnt   <= play_ticks(rom_dur, GAP5);
                            state     <= ST_PLAY;
                        end
                    end
                end

                ST_PLAY: begin
                    if (tick) begin
                        if (rem_cnt == 5'd1) begin
                            if (has_gap(dur_q, GAP5)) begin
                                tone_freq <= '0;
                                rem_cnt   <= GAP5;
                                state     <= ST_GAP;
                            end else begin
                                rom_addr <= addr_next;
                                state    <= ST_FETCH;
                            end
                        end else begin
                            rem_cnt <= rem_cnt - 5'd1;
                        end
                    end
                end

                ST_GAP: begin
                    if (tick) begin
                        if (rem_cnt == 5'd1) begin
                            rom_addr <= addr_next;
                            state    <= ST_FETCH;
                        end else begin
                            rem_cnt <= rem_cnt - 5'd1;
                        end
                    end
                end

                ST_FINISH: begin
                    if (done) begin
                        playing <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        rom_addr <= '0;
                        state    <= ST_FETCH;
                    end
                end

                default: begin
                    tone_freq <= '0;
                    playing   <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// -----------------------------------------------------------------------------
// tb_melody_sequencer
//   Self-checking bench for melody_sequencer with CLK_FREQ=100, TICK_HZ=10,
//   SONG_LEN=4, GAP_TICKS=1, ROM_LAT=2 and a 2-cycle ROM model. Expected
//   per-cycle outputs come from a song-level timing model (fetch, sound, gap
//   per entry) built from the ROM contents.
// -----------------------------------------------------------------------------
module tb_melody_sequencer;
    import melody_sequencer_pkg::*;

    localparam int TD  = 10;
    localparam int SL  = 4;
    localparam int G   = 1;
    localparam int LAT = 2;

    logic        sclk = 1'b0;
    logic        nrst;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [10:0] tone_freq;
    logic        playing;
    logic        done;

    logic [15:0] rom [SL];
    logic [15:0] rom_d1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];

    melody_sequencer #(
        .CLK_FREQ  (100),
        .TICK_HZ   (10),
        .SONG_LEN  (SL),
        .GAP_TICKS (G),
        .ROM_LAT   (LAT)
    ) dut (
        .sclk      (sclk),
        .nrst      (nrst),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .tone_freq (tone_freq),
        .playing   (playing),
        .done      (done)
    );

    always #5 sclk = ~sclk;

    // Two-stage synchronous ROM.
    always @(posedge sclk) begin
        rom_d1   <= rom[rom_addr[1:0]];
        rom_data <= rom_d1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] entry(input int dur, input int freq);
        return (16'(dur) << DUR_LSB) | 16'(freq & 2047);
    endfunction

    // Packed view: {tone[28:18], playing[17], done[16], addr[15:0]}
    function automatic logic [31:0] pack(input logic [10:0] t, input logic p,
                                         input logic d, input logic [15:0] a);
        return {3'b000, t, p, d, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got tone=%0d play=%0b done=%0b addr=%0d, expected tone=%0d play=%0b done=%0b addr=%0d",
                     name, act[28:18], act[17], act[16], act[15:0],
                     exp[28:18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    // Song-level model: sample 0 is the first cycle after start is taken.
    task automatic build_model(input bit loop, input int max_n);
        int          a    = 0;
        logic [10:0] prev = '0;
        bit          fin  = 1'b0;
        int          dur, pt, gp;
        logic [10:0] fr;
        exp_q.delete();
        while (exp_q.size() < max_n) begin
            if (fin) begin
                exp_q.push_back(pack(11'd0, 1'b0, 1'b0, 16'(a)));
            end else begin
                repeat (LAT + 1) exp_q.push_back(pack(prev, 1'b1, 1'b0, 16'(a)));
                dur = int'(rom[a][DUR_MSB:DUR_LSB]);
                fr  = rom[a][FREQ_MSB:0];
                if (dur == 0) begin
                    if (loop) begin
                        exp_q.push_back(pack(prev, 1'b1, 1'b0, 16'(a)));
                        a = 0;
                    end else begin
                        exp_q.push_back(pack(11'd0, 1'b1, 1'b1, 16'(a)));
                        fin = 1'b1;
                    end
                end else begin
                    pt = (dur > G) ? dur - G : dur;
                    gp = dur - pt;
                    repeat (pt * TD) exp_q.push_back(pack(fr, 1'b1, 1'b0, 16'(a)));
                    repeat (gp * TD) exp_q.push_back(pack(11'd0, 1'b1, 1'b0, 16'(a)));
                    prev = (gp > 0) ? 11'd0 : fr;
                    a    = (a + 1) % SL;
                end
            end
        end
    endtask

    // Start playback, compare n_cyc samples; optionally pulse start or stop
    // after sample start_at / stop_at.
    task automatic play_and_check(input string name, input bit loop, input int n_cyc,
                                  input int start_at, input int stop_at);
        logic [31:0] held;
        build_model(loop, n_cyc);
        if (stop_at >= 0) begin
            held = exp_q[stop_at];
            for (int k = stop_at + 1; k < n_cyc; k++)
                exp_q[k] = pack(11'd0, 1'b0, 1'b0, held[15:0]);
        end
        loop_en = loop;
        @(negedge sclk);
        start = 1'b1;
        for (int n = 0; n < n_cyc; n++) begin
            @(negedge sclk);
            check($sformatf("%s[%0d]", name, n), pack(tone_freq, playing, done, rom_addr), exp_q[n]);
            start = (n == start_at);
            stop  = (n == stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge sclk);
        stop = 1'b0;
        @(negedge sclk);
    endtask

    task automatic load_base_song();
        rom[0] = entry(3, 440);
        rom[1] = entry(2, 0);
        rom[2] = entry(0, 0);
        rom[3] = entry(0, 0);
    endtask

    typedef struct {
        bit          start;
        bit          stop;
        logic [10:0] tone;
        bit          playing;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{0, 0, 11'd0,   0};  // idle
        vecs[1]  = '{1, 1, 11'd0,   0};  // start+stop in IDLE: stop wins
        vecs[2]  = '{0, 0, 11'd0,   0};
        vecs[3]  = '{1, 0, 11'd0,   1};  // -> FETCH
        vecs[4]  = '{0, 1, 11'd0,   0};  // stop in FETCH
        vecs[5]  = '{0, 1, 11'd0,   0};  // stop in IDLE
        vecs[6]  = '{1, 0, 11'd0,   1};  // -> FETCH
        vecs[7]  = '{0, 0, 11'd0,   1};  // WAIT
        vecs[8]  = '{1, 0, 11'd0,   1};  // WAIT, start ignored
        vecs[9]  = '{0, 0, 11'd440, 1};  // PLAY
        vecs[10] = '{1, 1, 11'd0,   0};  // start+stop in PLAY: stop wins
        vecs[11] = '{0, 0, 11'd0,   0};

        load_base_song();

        // Reset state, checked right after asynchronous assertion.
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1 check("reset_async", pack(tone_freq, playing, done, rom_addr), pack(11'd0, 1'b0, 1'b0, 16'd0));
        repeat (3) @(negedge sclk);
        check("reset_held", pack(tone_freq, playing, done, rom_addr), pack(11'd0, 1'b0, 1'b0, 16'd0));
        nrst = 1'b1;
        @(negedge sclk);

        // Control vectors.
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            @(negedge sclk);
            check($sformatf("vec%0d", i), pack(tone_freq, playing, done, rom_addr),
                  pack(vecs[i].tone, vecs[i].playing, 1'b0, 16'd0));
        end
        start = 1'b0;
        stop  = 1'b0;
        @(negedge sclk);

        // Basic song to completion, then looping.
        play_and_check("basic", 1'b0, 64, -1, -1);
        play_and_check("loop", 1'b1, 130, -1, -1);
        stop_pulse();

        // Stop 7 cycles into the 440 note, then restart from address 0.
        play_and_check("stop_mid", 1'b0, 16, -1, 9);
        play_and_check("restart", 1'b0, 40, -1, -1);
        stop_pulse();

        // A start pulse during PLAY changes nothing.
        play_and_check("start_in_play", 1'b0, 64, 8, -1);

        // Address wrap with short notes and no end marker.
        for (int i = 0; i < SL; i++) rom[i] = entry(1, 262);
        play_and_check("wrap", 1'b0, 70, -1, -1);
        stop_pulse();

        // Asynchronous reset during the rest's gap (address 1).
        load_base_song();
        play_and_check("pre_rst", 1'b0, 51, -1, -1);
        #2 nrst = 1'b0;
        #1 check("rst_in_gap", pack(tone_freq, playing, done, rom_addr), pack(11'd0, 1'b0, 1'b0, 16'd0));
        @(negedge sclk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            check($sformatf("post_rst_idle%0d", i), pack(tone_freq, playing, done, rom_addr),
                  pack(11'd0, 1'b0, 1'b0, 16'd0));
        end
        play_and_check("after_rst", 1'b0, 40, -1, -1);
        stop_pulse();

        // Randomised songs against the model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < SL; i++) begin
                rom[i] = entry(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3)),
                               ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047)));
            end
            play_and_check($sformatf("rand%0d", r), bit'($urandom_range(0, 1)), 160, -1, -1);
            stop_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
